// File: rtl/gpr_pkg.sv
// Shared types and defaults for the general-purpose register file.
package gpr_pkg;

  typedef enum logic {
    GPR_CLEAR = 1'b0,
    GPR_RUN   = 1'b1
  } gpr_state_e;

  localparam int GPR_XLEN  = 32;
  localparam int GPR_NREGS = 32;

endpackage

// File: rtl/gpr_file_scoreboard.sv
// Per-register busy scoreboard; a reservation outranks a same-edge writeback.
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int NREGS = GPR_NREGS,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_nxt;

  always_comb begin
    w_nxt = r_busy;
    if (wr_en)  w_nxt[wr_addr]  = 1'b0;
    if (rsv_en) w_nxt[rsv_addr] = 1'b1;
    w_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_busy <= '0;
    else if (enable) r_busy <= w_nxt;
  end

  for (genvar g = 0; g < NRD; g++) begin : g_busy
    logic [AW-1:0] w_a;
    logic          w_hit;
    assign w_a   = rd_addr[g*AW +: AW];
    assign w_hit = wr_en && (wr_addr == w_a);
    assign rd_busy[g] = enable && r_busy[w_a] && !w_hit;
  end

endmodule

// File: rtl/gpr_file.sv
// Register file with x0 hardwired to zero, write bypass,
// post-reset clear sequencer and busy scoreboard.
module gpr_file
  import gpr_pkg::*;
#(
  parameter int XLEN  = GPR_XLEN,
  parameter int NREGS = GPR_NREGS,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic                ready
);

  gpr_state_e      r_state;
  logic [AW:0]     r_cnt;
  logic            r_ready;
  logic [XLEN-1:0] r_mem [NREGS];
  logic            w_run;

  assign w_run = (r_state == GPR_RUN);
  assign ready = r_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= GPR_CLEAR;
      r_cnt   <= (AW+1)'(1);
      r_ready <= 1'b0;
    end else begin
      unique case (r_state)
        GPR_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == (AW+1)'(NREGS-1)) begin
            r_state <= GPR_RUN;
            r_ready <= 1'b1;
          end
        end
        GPR_RUN: r_state <= GPR_RUN;
        default: r_state <= GPR_CLEAR;
      endcase
    end
  end

  // Storage carries no reset; the sequencer zeroes it after reset.
  always_ff @(posedge clk) begin
    if (!w_run)
      r_mem[r_cnt[AW-1:0]] <= '0;
    else if (wr_en && (wr_addr != '0))
      r_mem[wr_addr] <= wr_data;
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] w_a;
    assign w_a = rd_addr[g*AW +: AW];
    assign rd_data[g*XLEN +: XLEN] =
      (!w_run || (w_a == '0))        ? '0 :
      (wr_en && (wr_addr == w_a))    ? wr_data :
                                       r_mem[w_a];
  end

  gpr_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .AW    (AW)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (w_run),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy)
  );

endmodule
